// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I load/store unit driving a single req/ack data-memory transaction per operation.
// Define MEM_TIMEOUT_EN to abort a REQ that sees no bus_ack within TIMEOUT_CYCLES cycles.
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        stall,
   output logic        done,
   output logic        fault,
   output logic [31:0] mem_data,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);
   typedef enum logic {IDLE, REQ} state_t;
   state_t state_q, state_d;
   logic bus_req_q, bus_req_d, bus_we_q, bus_we_d, done_q, done_d, fault_q, fault_d;
   logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d, mem_data_q, mem_data_d;
   logic [3:0] bus_wstrb_q, bus_wstrb_d;
   logic [2:0] f3_q, f3_d;
   logic [1:0] off_q, off_d;
   logic accept, legal, misaligned, go, timeout;
   logic [7:0] ld_b;
   logic [15:0] ld_h;
   logic [31:0] ld_val;
   always_comb begin
      accept     = state_q == IDLE && start && (mem_read || mem_write);
      legal      = mem_write ? funct3 inside {3'd0, 3'd1, 3'd2} : funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      misaligned = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
      go         = accept && legal && !misaligned;
      ld_b       = bus_rdata[8*off_q +: 8];
      ld_h       = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      ld_val     = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & ld_b[7]}}, ld_b} :
                   f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & ld_h[15]}}, ld_h} : bus_rdata;
   end
`ifdef MEM_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;
   always_comb begin
      cnt_d   = go ? 16'd0 : (state_q == REQ && !bus_ack) ? cnt_q + 16'd1 : cnt_q;
      timeout = state_q == REQ && cnt_q + 16'd1 == TIMEOUT_CYCLES[15:0];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= 16'd0;
      else     cnt_q <= cnt_d;
`else
   // TIMEOUT_CYCLES is at least 1, so this is a constant-false tie-off that still references the parameter
   assign timeout = TIMEOUT_CYCLES == 0;
`endif
   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_wstrb_d = bus_wstrb_q;
      mem_data_d  = mem_data_q;
      f3_d        = f3_q;
      off_d       = off_q;
      done_d      = 1'b0;
      fault_d     = 1'b0;
      if (accept && !go) begin
         done_d  = 1'b1;
         fault_d = 1'b1;
      end else if (go) begin
         state_d     = REQ;
         bus_req_d   = 1'b1;
         bus_we_d    = mem_write;
         bus_addr_d  = {addr[31:2], 2'b00};
         bus_wdata_d = funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} :
                       funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
         bus_wstrb_d = !mem_write ? 4'b0000 :
                       funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
                       funct3[1:0] == 2'b01 ? 4'b0011 << addr[1:0] : 4'b1111;
         f3_d        = funct3;
         off_d       = addr[1:0];
      end else if (state_q == REQ && (bus_ack || timeout)) begin
         state_d    = IDLE;
         bus_req_d  = 1'b0;
         done_d     = 1'b1;
         fault_d    = !bus_ack;
         mem_data_d = bus_ack && !bus_we_q ? ld_val : mem_data_q;
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q     <= IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'd0;
         bus_wdata_q <= 32'd0;
         bus_wstrb_q <= 4'd0;
         mem_data_q  <= 32'd0;
         f3_q        <= 3'd0;
         off_q       <= 2'd0;
         done_q      <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_wstrb_q <= bus_wstrb_d;
         mem_data_q  <= mem_data_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
         done_q      <= done_d;
         fault_q     <= fault_d;
      end
   assign stall     = accept || state_q == REQ;
   assign done      = done_q;
   assign fault     = fault_q;
   assign mem_data  = mem_data_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_wstrb = bus_wstrb_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized load/store traffic checked against a byte-level reference model.
module tb_mem_access_unit;
   logic clk = 1'b0, rst, start, mem_read, mem_write, bus_ack;
   logic [2:0] funct3;
   logic [31:0] addr, store_data, bus_rdata;
   logic stall, done, fault, bus_req, bus_we;
   logic [31:0] mem_data, bus_addr, bus_wdata;
   logic [3:0] bus_wstrb;
   int n_chk = 0, n_bad = 0;
   logic [31:0] exp_mem = 32'd0;
   localparam int TO = 4;
`ifdef MEM_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .mem_read(mem_read), .mem_write(mem_write),
      .funct3(funct3), .addr(addr), .store_data(store_data), .stall(stall), .done(done),
      .fault(fault), .mem_data(mem_data), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         start = 1'($urandom % 2);
         mem_read = 1'b0;
         mem_write = 1'b0;
         funct3 = 3'($urandom);
         addr = $urandom;
         bus_ack = 1'($urandom % 2);
         bus_rdata = $urandom;
         @(posedge clk);
         #1;
         check("idle_done", done, 0);
         check("idle_req", bus_req, 0);
         check("idle_stall", stall, 0);
         check("idle_mem", mem_data, exp_mem);
      end
      start = 1'b0;
      bus_ack = 1'b0;
   endtask
   // wr/rd_too: store (load flag also set when rd_too); dly: REQ cycles before the ack cycle
   task automatic do_op(input bit wr, input bit rd_too, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input int dly, input logic [31:0] rdata);
      int nb;
      bit ok, tmo;
      logic [3:0] es;
      logic [31:0] ew, sh, mask;
      nb = 1 << f3[1:0];
      ok = wr ? f3 < 3 : (f3 < 3 || f3 == 4 || f3 == 5);
      ok = ok && (a % nb == 0);
      es = 4'd0;
      ew = 32'd0;
      if (ok) begin
         for (int i = 0; i < 4; i++) ew[8*i +: 8] = sd[8*(i % nb) +: 8];
         if (wr) for (int i = 0; i < nb; i++) es[int'(a[1:0]) + i] = 1'b1;
      end
      @(negedge clk);
      bus_ack = 1'b0;
      start = 1'b1;
      mem_write = wr;
      mem_read = !wr || rd_too;
      funct3 = f3;
      addr = a;
      store_data = sd;
      bus_rdata = $urandom;
      #1;
      check("acc_stall", stall, 1);
      @(posedge clk);
      #1;
      start = 1'b0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      funct3 = 3'($urandom);
      addr = $urandom;
      store_data = $urandom;
      if (!ok) begin
         check("bad_req", bus_req, 0);
         check("bad_done", done, 1);
         check("bad_fault", fault, 1);
         check("bad_mem", mem_data, exp_mem);
         return;
      end
      tmo = TO_EN && dly >= TO;
      for (int c = 0; c <= (tmo ? TO - 1 : dly); c++) begin
         check("req", bus_req, 1);
         check("we", bus_we, wr);
         check("addr", bus_addr, a & ~32'd3);
         check("strb", bus_wstrb, es);
         if (wr) check("wdata", bus_wdata, ew);
         check("req_done", done, 0);
         check("req_stall", stall, 1);
         if (c < (tmo ? TO - 1 : dly)) begin
            @(posedge clk);
            #1;
         end
      end
      if (tmo) begin
         @(posedge clk);
         #1;
         check("to_done", done, 1);
         check("to_fault", fault, 1);
         check("to_req", bus_req, 0);
         check("to_mem", mem_data, exp_mem);
         return;
      end
      @(negedge clk);
      bus_ack = 1'b1;
      bus_rdata = rdata;
      @(posedge clk);
      #1;
      bus_ack = 1'b0;
      bus_rdata = $urandom;
      if (!wr) begin
         sh = rdata >> (8 * int'(a[1:0]));
         mask = 32'hFFFF_FFFF >> (32 - 8 * nb);
         exp_mem = sh & mask;
         if (!f3[2] && nb < 4 && sh[8*nb-1]) exp_mem = exp_mem | ~mask;
      end
      check("ack_done", done, 1);
      check("ack_fault", fault, 0);
      check("ack_req", bus_req, 0);
      check("ack_stall", stall, 0);
      check("ack_mem", mem_data, exp_mem);
   endtask
   initial begin
      rst = 1'b1;
      start = 1'b0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      funct3 = 3'd0;
      addr = 32'd0;
      store_data = 32'd0;
      bus_ack = 1'b0;
      bus_rdata = 32'd0;
      #3;
      check("rst_req", bus_req, 0);
      check("rst_done", done, 0);
      check("rst_fault", fault, 0);
      check("rst_mem", mem_data, 0);
      check("rst_strb", bus_wstrb, 0);
      check("rst_addr", bus_addr, 0);
      check("rst_stall", stall, 0);
      @(negedge clk);
      rst = 1'b0;
      idle(2);
      do_op(0, 0, 3'b000, 32'h1003, 32'h0, 2, 32'h80AABBCC);
      check("lb_val", mem_data, 32'hFFFFFF80);
      idle(1);
      do_op(1, 0, 3'b001, 32'h2002, 32'h1234ABCD, 1, $urandom);
      check("sh_mem", mem_data, 32'hFFFFFF80);
      do_op(0, 0, 3'b101, 32'h4002, 32'h0, 0, 32'h80010000);
      check("lhu_val", mem_data, 32'h00008001);
      do_op(0, 0, 3'b010, 32'h3001, 32'h0, 0, $urandom);
      check("lw_mis_mem", mem_data, 32'h00008001);
      idle(1);
      @(negedge clk);
      start = 1'b1;
      mem_read = 1'b1;
      funct3 = 3'b010;
      addr = 32'h100;
      @(posedge clk);
      #1;
      start = 1'b0;
      mem_read = 1'b0;
      check("pre_rst_req", bus_req, 1);
      #2 rst = 1'b1;
      #1;
      check("async_req", bus_req, 0);
      rst = 1'b0;
      exp_mem = 32'd0;
      @(posedge clk);
      #1;
      check("post_rst_done", done, 0);
      check("post_rst_mem", mem_data, 0);
      do_op(1, 0, 3'b000, 32'h10, 32'hA5, 1, $urandom);
      do_op(0, 0, 3'b010, 32'h200, 32'h0, 10, 32'hCAFEF00D);
      do_op(0, 0, 3'b100, 32'h201, 32'h0, TO - 1, 32'h0000F300);
      for (int k = 0; k < 150; k++) begin
         idle($urandom % 3);
         do_op(1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom % 7, $urandom);
      end
      idle(2);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
